// File: rtl/i2c_slave_regs.sv
// i2c_slave_regs: I2C-style bus slave in front of a 32x8 register file.
// A transaction is START, a 13-bit LSB-first header {addr[6:0], mem_addr[4:0], rw}
// (rw first), an ACK slot, one data byte (written by the master when rw=1,
// returned by the slave when rw=0) and a final ACK slot. SCL/SDA are oversampled
// with clk; SDA is only ever pulled low or released, SCL is never driven.
//
// Ports:
//   clk       system clock, all logic on posedge
//   rst       asynchronous active-low reset
//   sda       bus data (open drain: 0 or z)
//   scl       bus clock (always z from this block)
//   reg_addr  local read address
//   reg_data  regs[reg_addr], combinational
//   wr_valid  one-clk pulse when a bus write commits
//   wr_addr   register address of the last committed write
//   wr_data   data of the last committed write
//   busy      high while a transaction is being tracked
//
// Build option: define I2C_SLAVE_GLITCH_FILTER_EN to add a 3-sample majority
// filter after each synchronizer (+2 clk latency, rejects pulses <= 1 clk).
module i2c_slave_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire        sda,
  inout  wire        scl,
  input  logic [4:0] reg_addr,
  output logic [7:0] reg_data,
  output logic       wr_valid,
  output logic [4:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, HEADER, HDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  state_t      state, state_n;
  logic [3:0]  bit_cnt, bit_cnt_n;
  logic [12:0] hdr, hdr_n, hdr_shift;
  logic [7:0]  dat, dat_n;
  logic        sda_low, sda_low_n;
  logic        commit;
  logic [7:0]  regs [32];
  logic [4:0]  mem_addr;

  // Bus pins: SDA is pulled low or left floating; SCL belongs to the master.
  assign sda = sda_low ? 1'b0 : 1'bz;
  assign scl = 1'bz;

  // Two-flop synchronizers, reset to the idle bus level so reset release
  // cannot fabricate a START.
  logic [1:0] scl_sync, sda_sync;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda};
    end
  end

  logic scl_c, sda_c;
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic [1:0] scl_hist, sda_hist;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_hist <= 2'b11;
      sda_hist <= 2'b11;
      scl_c    <= 1'b1;
      sda_c    <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[0], scl_sync[1]};
      sda_hist <= {sda_hist[0], sda_sync[1]};
      scl_c    <= maj3(scl_sync[1], scl_hist[0], scl_hist[1]);
      sda_c    <= maj3(sda_sync[1], sda_hist[0], sda_hist[1]);
    end
  end
`else
  assign scl_c = scl_sync[1];
  assign sda_c = sda_sync[1];
`endif

  // Previous conditioned samples for edge detection.
  logic scl_p, sda_p;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_p <= 1'b1;
      sda_p <= 1'b1;
    end else begin
      scl_p <= scl_c;
      sda_p <= sda_c;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_c & ~scl_p;
  assign scl_fall  = ~scl_c & scl_p;
  assign start_det = scl_c & scl_p & ~sda_c & sda_p;
  assign stop_det  = scl_c & scl_p & sda_c & ~sda_p;

  assign mem_addr  = hdr[5:1];
  assign hdr_shift = {sda_c, hdr[12:1]};
  assign reg_data  = regs[reg_addr];
  assign busy      = (state != IDLE);

  // In both ACK states bit_cnt doubles as a phase flag: 0 = waiting for the
  // fall that starts the ACK, 1 = ACK is being driven.
  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    hdr_n     = hdr;
    dat_n     = dat;
    sda_low_n = sda_low;
    commit    = 1'b0;
    if (stop_det) begin
      state_n   = IDLE;
      sda_low_n = 1'b0;
    end else if (start_det) begin
      state_n   = HEADER;
      bit_cnt_n = 4'd0;
      sda_low_n = 1'b0;
    end else begin
      case (state)
        HEADER: if (scl_rise) begin
          hdr_n = hdr_shift;
          if (bit_cnt == 4'd12) begin
            bit_cnt_n = 4'd0;
            state_n   = (hdr_shift[12:6] == SLAVE_ADDR) ? HDR_ACK : WAIT_STOP;
          end else begin
            bit_cnt_n = bit_cnt + 4'd1;
          end
        end
        HDR_ACK: if (scl_fall) begin
          if (bit_cnt == 4'd0) begin
            sda_low_n = 1'b1;
            bit_cnt_n = 4'd1;
          end else begin
            bit_cnt_n = 4'd0;
            if (hdr[0]) begin
              state_n   = WR_DATA;
              sda_low_n = 1'b0;
            end else begin
              state_n   = RD_DATA;
              dat_n     = regs[mem_addr];
              sda_low_n = ~regs[mem_addr][0];
            end
          end
        end
        WR_DATA: if (scl_rise) begin
          dat_n = {sda_c, dat[7:1]};
          if (bit_cnt == 4'd7) begin
            commit    = 1'b1;
            bit_cnt_n = 4'd0;
            state_n   = WR_ACK;
          end else begin
            bit_cnt_n = bit_cnt + 4'd1;
          end
        end
        WR_ACK: if (scl_fall) begin
          if (bit_cnt == 4'd0) begin
            sda_low_n = 1'b1;
            bit_cnt_n = 4'd1;
          end else begin
            sda_low_n = 1'b0;
            bit_cnt_n = 4'd0;
            state_n   = WAIT_STOP;
          end
        end
        RD_DATA: if (scl_fall) begin
          if (bit_cnt == 4'd7) begin
            sda_low_n = 1'b0;
            bit_cnt_n = 4'd0;
            state_n   = RD_ACK;
          end else begin
            sda_low_n = ~dat[1];
            dat_n     = {1'b0, dat[7:1]};
            bit_cnt_n = bit_cnt + 4'd1;
          end
        end
        RD_ACK: if (scl_rise) state_n = WAIT_STOP;
        default: ;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values of the previous cycle, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      bit_cnt  <= 4'd0;
      hdr      <= 13'd0;
      dat      <= 8'd0;
      sda_low  <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= 5'd0;
      wr_data  <= 8'd0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      hdr      <= hdr_n;
      dat      <= dat_n;
      sda_low  <= sda_low_n;
      wr_valid <= commit;
      if (commit) begin
        wr_addr <= mem_addr;
        wr_data <= dat_n;
      end
    end
  end

  // NOTE: the register file is reset because it must read 8'h00 after reset;
  // this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 8'h00;
    end else if (commit) begin
      regs[mem_addr] <= dat_n;
    end
  end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Self-checking bench for i2c_slave_regs: directed bus scenarios plus random
// transactions checked against an array model of the register file.
module tb_i2c_slave_regs;
  localparam int HP = 16;        // SCL half period in clk cycles
  localparam int Q  = HP / 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  tri1        sda;
  tri1        scl;
  logic       m_sda_low = 1'b0;
  logic       m_scl_low = 1'b0;
  logic [4:0] reg_addr = 5'd0;
  logic [7:0] reg_data;
  logic       wr_valid;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  assign sda = m_sda_low ? 1'b0 : 1'bz;
  assign scl = m_scl_low ? 1'b0 : 1'bz;

  i2c_slave_regs #(.SLAVE_ADDR(7'h50)) dut (
    .clk      (clk),
    .rst      (rst),
    .sda      (sda),
    .scl      (scl),
    .reg_addr (reg_addr),
    .reg_data (reg_data),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] model [32];

  // Bus monitor, sampled 1 time unit after the falling edge.
  int         wv_cnt = 0;
  int         slave_pull = 0;
  logic [4:0] wv_addr = '0;
  logic [7:0] wv_data = '0;
  logic [7:0] last_reg_data = '0;
  logic [7:0] pre_commit_data = '0;
  logic [7:0] commit_reg_data = '0;
  logic       busy_seen = 1'b0;

  always @(negedge clk) begin
    #1;
    if (wr_valid) begin
      wv_cnt++;
      wv_addr = wr_addr;
      wv_data = wr_data;
      pre_commit_data = last_reg_data;
      commit_reg_data = reg_data;
    end
    last_reg_data = reg_data;
    if (sda === 1'b0 && !m_sda_low) slave_pull++;
    if (busy) busy_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One bit slot starting and ending with SCL low; obs is SDA mid-high.
  task automatic send_bit(input logic b, output logic obs);
    m_sda_low = !b;
    clk_wait(Q);
    m_scl_low = 1'b0;
    clk_wait(Q);
    obs = sda;
    clk_wait(Q);
    m_scl_low = 1'b1;
    clk_wait(Q);
  endtask

  task automatic send_start();
    m_sda_low = 1'b0;
    clk_wait(Q);
    m_scl_low = 1'b0;
    clk_wait(Q);
    m_sda_low = 1'b1;
    clk_wait(Q);
    m_scl_low = 1'b1;
    clk_wait(Q);
  endtask

  task automatic send_stop();
    m_sda_low = 1'b1;
    clk_wait(Q);
    m_scl_low = 1'b0;
    clk_wait(Q);
    m_sda_low = 1'b0;
    clk_wait(HP);
  endtask

  task automatic xfer(input logic [6:0] a, input logic [4:0] m, input logic rw,
                      input logic [7:0] d, input int nbits,
                      output logic h, output logic [7:0] rd, output logic k);
    logic [12:0] hdr;
    logic        o;
    hdr = {a, m, rw};
    rd  = 8'h00;
    k   = 1'b1;
    send_start();
    for (int i = 0; i < 13; i++) send_bit(hdr[i], o);
    send_bit(1'b1, h);
    if (rw) begin
      for (int i = 0; i < nbits; i++) send_bit(d[i], o);
      if (nbits == 8) send_bit(1'b1, k);
    end else begin
      for (int i = 0; i < 8; i++) begin
        send_bit(1'b1, o);
        rd[i] = o;
      end
      send_bit(1'b1, k);
    end
    send_stop();
  endtask

  // Full transaction plus all checks derived from the register-file model.
  task automatic txn(input logic [6:0] a, input logic [4:0] m, input logic rw,
                     input logic [7:0] d, input int nbits);
    logic       h, k, match, commit;
    logic [7:0] rd;
    int         wv0;
    match  = (a == 7'h50);
    commit = match && rw && (nbits == 8);
    wv0    = wv_cnt;
    slave_pull = 0;
    xfer(a, m, rw, d, nbits, h, rd, k);
    clk_wait(4);
    check("hdr_ack", {31'd0, h}, {31'd0, !match});
    if (rw) begin
      if (nbits == 8) check("wr_ack", {31'd0, k}, {31'd0, !match});
    end else begin
      check("rd_data", {24'd0, rd}, {24'd0, (match ? model[m] : 8'hFF)});
      check("rd_release", {31'd0, k}, 32'd1);
    end
    check("wr_valid_cnt", wv_cnt - wv0, {31'd0, commit});
    if (commit) begin
      check("wr_addr", {27'd0, wv_addr}, {27'd0, m});
      check("wr_data", {24'd0, wv_data}, {24'd0, d});
      model[m] = d;
    end
    if (!match) check("no_drive", slave_pull, 0);
    check("busy_idle", {31'd0, busy}, 32'd0);
    reg_addr = m;
    clk_wait(1);
    check("reg_data", {24'd0, reg_data}, {24'd0, model[m]});
  endtask

  initial begin
    #9_000_000;
    $display("FAIL watchdog: time limit reached, got no end, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        o;
    logic [12:0] hdr;
    logic [6:0]  a;
    logic [4:0]  m;
    logic        rw;
    logic [7:0]  d;
    int          nb;

    for (int i = 0; i < 32; i++) model[i] = 8'h00;

    // Reset state.
    #2 rst = 1'b0;
    clk_wait(4);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
    check("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {24'd0, wr_data}, 32'd0);
    check("rst_reg_data", {24'd0, reg_data}, 32'd0);
    check("rst_sda", {31'd0, sda}, 32'd1);
    check("rst_scl", {31'd0, scl}, 32'd1);
    rst = 1'b1;
    clk_wait(HP);

    // Write 8'hA5 to mem 3; local read of reg 3 stays old until the commit clk.
    reg_addr  = 5'd3;
    busy_seen = 1'b0;
    txn(7'h50, 5'd3, 1'b1, 8'hA5, 8);
    check("busy_seen", {31'd0, busy_seen}, 32'd1);
    check("old_before_commit", {24'd0, pre_commit_data}, 32'h00);
    check("new_at_commit", {24'd0, commit_reg_data}, 32'hA5);

    // Read mem 3 back: bits 1,0,1,0,0,1,0,1 LSB-first.
    txn(7'h50, 5'd3, 1'b0, 8'h00, 8);

    // Address mismatch, write and read.
    txn(7'h51, 5'd3, 1'b1, 8'h12, 8);
    txn(7'h51, 5'd3, 1'b0, 8'h00, 8);

    // STOP after 4 data bits.
    txn(7'h50, 5'd7, 1'b1, 8'hFF, 4);

    // Repeated START mid-header, then a full write of 8'h3C to mem 31.
    hdr = {7'h50, 5'd31, 1'b1};
    send_start();
    for (int i = 0; i < 6; i++) send_bit(hdr[i], o);
    txn(7'h50, 5'd31, 1'b1, 8'h3C, 8);

    // Reset while the header ACK is being driven.
    reg_addr = 5'd3;
    hdr = {7'h50, 5'd5, 1'b1};
    send_start();
    for (int i = 0; i < 13; i++) send_bit(hdr[i], o);
    clk_wait(2);
    check("ack_driven", {31'd0, sda}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_mid_sda", {31'd0, sda}, 32'd1);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_regs", {24'd0, reg_data}, 32'h00);
    for (int i = 0; i < 32; i++) model[i] = 8'h00;
    @(negedge clk);
    m_sda_low = 1'b0;
    m_scl_low = 1'b0;
    clk_wait(4);
    rst = 1'b1;
    clk_wait(HP);
    txn(7'h50, 5'd9, 1'b1, 8'h5A, 8);

    // Random traffic.
    for (int t = 0; t < 30; t++) begin
      a  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'h50;
      m  = 5'($urandom_range(0, 31));
      rw = 1'($urandom_range(0, 1));
      d  = 8'($urandom_range(0, 255));
      nb = (rw && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : 8;
      txn(a, m, rw, d, nb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_slave_regs.md
# i2c_slave_regs

I2C-style slave with a 32×8 register file, the bus-side counterpart of the team's `i2c_master`. It decodes a START, a 13-bit LSB-first header `{addr[6:0], mem_addr[4:0], rw}` (rw sent first) and one data byte, then acknowledges, stores or returns register data, and exposes the register file to local logic. It oversamples SCL/SDA with the system clock and drives SDA open-drain only. It never drives SCL.

## Interface
- `SLAVE_ADDR`, default 7'h50: 7-bit address this slave answers to.
- `clk  in  1`: system clock; all logic on posedge.
- `rst  in  1`: asynchronous, active-low reset.
- `sda  inout  1 (tri1)`: bus data, driven only as 0 or z.
- `scl  inout  1 (tri1)`: bus clock, never driven (always z).
- `reg_addr  in  5`: local read address.
- `reg_data  out  8`: combinational `regs[reg_addr]`.
- `wr_valid  out  1`: one-clk pulse when a bus write commits.
- `wr_addr  out  5`: register address of the last committed write.
- `wr_data  out  8`: data of the last committed write.
- `busy  out  1`: high whenever state ≠ IDLE.

## Operation
- **Input conditioning:** 2-flop synchronizers on SCL and SDA. Edges are detected on the synchronized values.
  - START = SDA fall while SCL high.
  - STOP = SDA rise while SCL high.
  - Data is sampled on the SCL rise.
  - SDA is changed by the slave one clk after the SCL fall.
- **States:** IDLE, HEADER, HDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- **IDLE → HEADER** on START; bit counter is cleared.
- **HEADER:** shifts in 13 bits LSB-first (bit0 = rw, bits1-5 = mem_addr, bits6-12 = addr). After the 13th rise:
  - addr = SLAVE_ADDR → HDR_ACK.
  - addr ≠ SLAVE_ADDR → WAIT_STOP, SDA never driven.
- **HDR_ACK:** SDA is pulled low from the SCL fall after bit 13 until the next SCL fall. On that fall:
  - rw = 1 (write) → WR_DATA.
  - rw = 0 (read) → RD_DATA. Snapshot `regs[mem_addr]` into the shift register and drive bit0 immediately.
- **WR_DATA:** 8 bits sampled LSB-first. On the 8th rise:
  - Next clk: `regs[mem_addr]`, `wr_addr` and `wr_data` update, and `wr_valid` pulses for 1 clk.
  - Then → WR_ACK.
- **WR_ACK:** SDA low for one SCL period (fall to fall) → WAIT_STOP.
- **RD_DATA:** bits driven LSB-first, each changed on an SCL fall. After the 8th bit's fall, SDA is released → RD_ACK.
- **RD_ACK:** samples the master's ACK/NACK on the SCL rise (ignored, no effect) → WAIT_STOP.
- **WAIT_STOP:** SDA released; waits for STOP or START.
- **Global rules, any state:**
  - STOP → IDLE, SDA released, no commit.
  - START (repeated) → HEADER.
  - START/STOP take priority over a same-clk data sample.
- **Local reads vs bus writes:** a local `reg_data` read during a bus write shows the old value until the commit clk.

## Timing
- SCL high and low phases must each be ≥ 4 clk periods (≥ 6 with the glitch filter). Faster SCL is unsupported.
- Input latency is 2 clk from pin to synchronized value (+2 with the filter).
- Write commit occurs 1 clk after the 8th data-bit rise is detected.
- SDA drive changes 1 clk after a detected SCL fall. This keeps hold time for the master well inside SCL low.
- **Reset values:** SDA z, SCL z, all regs 8'h00, `wr_valid` 0, `wr_addr` 0, `wr_data` 0, `busy` 0, `reg_data` 8'h00.
- **Reset mid-transaction:** SDA is released immediately (asynchronous); the partial write is discarded.

## Configuration
- `I2C_SLAVE_GLITCH_FILTER_EN` defined:
  - A 3-sample majority filter is inserted after each synchronizer, adding 2 clk latency.
  - Pulses ≤ 1 clk on SCL/SDA are rejected.
- Undefined: no filter; synchronizer output is used directly.

## Test plan
- **Write:** START, header addr = 7'h50, mem = 5'd3, rw = 1, data 8'hA5, STOP.
  - ACK low on both ack slots.
  - `wr_valid` pulses once, with `wr_addr` = 3 and `wr_data` = A5.
  - `reg_addr` = 3 then gives `reg_data` = A5.
- **Read:** preload reg 3 = 8'hA5, then read mem = 3 with rw = 0. SDA carries header ACK 0, then bits 1,0,1,0,0,1,0,1 LSB-first, then is released.
- **Address mismatch:** header addr = 7'h51. SDA stays high for the whole transaction, no `wr_valid`, `busy` returns 0 after STOP.
- **STOP after 4 write data bits:** state → IDLE, no `wr_valid`, reg unchanged.
- **Repeated START mid-header, then a full write of 8'h3C to mem 31:** reg 31 = 3C, `wr_valid` pulses once.
- **Reset asserted while driving an ACK:** SDA → z in the same cycle, all regs 0, `busy` 0. A fresh write works after release.
